// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator running one 16-bit {addr, rw, data} transaction per start request.
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
  state_t state, state_d;
  logic [DW-1:0] div, div_d;
  logic [3:0] cnt, cnt_d;
  logic ph, ph_d;
  logic [14:0] sh, sh_d;
  logic [7:0] rx, rx_d, rdata_d;
  logic rw_l, rw_d, sclk_d, cs_n_d, mosi_d, busy_d, done_d;
  logic tick, acc, fall, rise, fin;
  assign tick = div == DW'(CLK_DIV - 1);
  assign acc  = state == IDLE && start;
  assign fall = state == SHIFT && !ph && tick;
  // bit counter advances on falls, so it reads 0 in a low half only after the 16th fall
  assign fin  = state == SHIFT && ph && tick && cnt == 4'd0;
  assign rise = (state == SETUP && tick) || (state == SHIFT && ph && tick && cnt != 4'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      div   <= '0;
      cnt   <= '0;
      ph    <= 1'b0;
      sh    <= '0;
      rx    <= '0;
      rw_l  <= 1'b0;
      sclk  <= 1'b0;
      cs_n  <= 1'b1;
      mosi  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_d;
      div   <= div_d;
      cnt   <= cnt_d;
      ph    <= ph_d;
      sh    <= sh_d;
      rx    <= rx_d;
      rw_l  <= rw_d;
      sclk  <= sclk_d;
      cs_n  <= cs_n_d;
      mosi  <= mosi_d;
      busy  <= busy_d;
      done  <= done_d;
      rdata <= rdata_d;
    end
  end
  always_comb begin
    state_d = state == IDLE  ? (start ? SETUP : IDLE) :
              state == SETUP ? (tick ? SHIFT : SETUP) :
              state == SHIFT ? (fin ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    div_d   = (state == SETUP || state == SHIFT) && !tick ? div + DW'(1) : '0;
    ph_d    = state == SHIFT && (ph ^ tick);
    cnt_d   = state != SHIFT ? 4'd0 : fall ? cnt + 4'd1 : cnt;
    sh_d    = acc ? {addr[5:0], rw, rw ? 8'h00 : wdata} : fall ? {sh[13:0], 1'b0} : sh;
    mosi_d  = acc ? addr[6] : fall ? sh[14] : mosi;
    rx_d    = rise && cnt[3] ? {rx[6:0], miso} : rx;
    rw_d    = acc ? rw : rw_l;
    sclk_d  = rise | (sclk & ~fall);
    cs_n_d  = state == IDLE ? !start : (state == DONE || fin);
    busy_d  = state == IDLE ? start : state != DONE;
    done_d  = fin;
    rdata_d = fin && rw_l ? rx : rdata;
  end
endmodule
